// File: rtl/plm_dp_port_arbiter.sv
// ---------------------------------------------------------------------------
// PlmDpPortArbiter: front-end for a true-dual-port PLM bank.
//
// Purpose
//   Shares the two physical ports of a dual-port memory bank between NREQ
//   accelerator channels. Arbitration is round-robin. A second grant in the
//   same cycle is refused when it would touch the port-0 address with a write
//   involved. Read data is steered back to the issuing channel by a tag
//   pipeline whose depth matches the bank read latency.
//
// Ports
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   per-channel request handshake (accept = valid & ready)
//   req_we                per-channel write (1) / read (0)
//   req_addr, req_data    per-channel address / write data, packed by channel
//   rsp_valid, rsp_data   per-channel read response, packed by channel
//   A0/A1, D0/D1          bank port address / write data
//   CE0/CE1, WE0/WE1      bank port enable / write enable
//   WEM0/WEM1             bank write mask (all ones on a write)
//   Q0/Q1                 bank port read data
// ---------------------------------------------------------------------------
module plm_dp_port_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [NREQ*DATA_W-1:0]   rsp_data,
    output logic [ADDR_W-1:0]        A0,
    output logic [ADDR_W-1:0]        A1,
    output logic [DATA_W-1:0]        D0,
    output logic [DATA_W-1:0]        D1,
    output logic                     CE0,
    output logic                     CE1,
    output logic                     WE0,
    output logic                     WE1,
    output logic [DATA_W-1:0]        WEM0,
    output logic [DATA_W-1:0]        WEM1,
    input  logic [DATA_W-1:0]        Q0,
    input  logic [DATA_W-1:0]        Q1
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Round-robin start point for the scan.
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;

    // Current-cycle grant decisions for port 0 and port 1.
    logic              g0_valid;
    logic [PTR_W-1:0]  g0_idx;
    logic              g0_we;
    logic [ADDR_W-1:0] g0_addr;
    logic              g1_valid;
    logic [PTR_W-1:0]  g1_idx;
    logic              g1_we;

    // Read tags in flight, one lane per bank port (lane index = port).
    logic              tag_v  [2][RD_LAT];
    logic [PTR_W-1:0]  tag_ch [2][RD_LAT];

    // Scan channels starting at ptr. The first valid channel takes port 0.
    // Later channels are tried for port 1 and skipped (not stopped at) when
    // they hit the port-0 address with a write on either side. Two reads of
    // the same address are harmless and both go through.
    always_comb begin
        logic [PTR_W-1:0] cand;
        logic             cand_conflict;
        g0_valid      = 1'b0;
        g0_idx        = '0;
        g0_we         = 1'b0;
        g0_addr       = '0;
        g1_valid      = 1'b0;
        g1_idx        = '0;
        g1_we         = 1'b0;
        cand          = '0;
        cand_conflict = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NREQ);
            if (req_valid[cand]) begin
                if (!g0_valid) begin
                    g0_valid = 1'b1;
                    g0_idx   = cand;
                    g0_we    = req_we[cand];
                    g0_addr  = req_addr[cand*ADDR_W +: ADDR_W];
                end else if (!g1_valid) begin
                    cand_conflict = (req_addr[cand*ADDR_W +: ADDR_W] == g0_addr)
                                    && (g0_we || req_we[cand]);
                    if (!cand_conflict) begin
                        g1_valid = 1'b1;
                        g1_idx   = cand;
                        g1_we    = req_we[cand];
                    end
                end
            end
        end
    end

    // Handshake back to the channels and the next scan start point, which is
    // just past the last channel granted this cycle.
    always_comb begin
        req_ready = '0;
        ptr_d     = ptr_q;
        if (g0_valid) begin
            req_ready[g0_idx] = 1'b1;
            ptr_d = PTR_W'((int'(g0_idx) + 1) % NREQ);
        end
        if (g1_valid) begin
            req_ready[g1_idx] = 1'b1;
            ptr_d = PTR_W'((int'(g1_idx) + 1) % NREQ);
        end
    end

    // Bank port drive. Everything is forced to zero on an idle port so the
    // bank sees clean, quiet inputs.
    always_comb begin
        CE0  = g0_valid;
        WE0  = g0_valid & g0_we;
        A0   = g0_valid ? g0_addr : '0;
        D0   = g0_valid ? req_data[g0_idx*DATA_W +: DATA_W] : '0;
        WEM0 = {DATA_W{WE0}};
        CE1  = g1_valid;
        WE1  = g1_valid & g1_we;
        A1   = g1_valid ? req_addr[g1_idx*ADDR_W +: ADDR_W] : '0;
        D1   = g1_valid ? req_data[g1_idx*DATA_W +: DATA_W] : '0;
        WEM1 = {DATA_W{WE1}};
    end

    // Round-robin pointer register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Tag shift pipeline. Stage 0 captures this cycle's read grants and the
    // last stage lines up with Q of the same port. Reset drops any reads in
    // flight so they never produce a response.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < RD_LAT; s++) begin
                    tag_v[p][s]  <= 1'b0;
                    tag_ch[p][s] <= '0;
                end
            end
        end else begin
            tag_v[0][0]  <= g0_valid & ~g0_we;
            tag_ch[0][0] <= g0_idx;
            tag_v[1][0]  <= g1_valid & ~g1_we;
            tag_ch[1][0] <= g1_idx;
            for (int p = 0; p < 2; p++) begin
                for (int s = 1; s < RD_LAT; s++) begin
                    tag_v[p][s]  <= tag_v[p][s-1];
                    tag_ch[p][s] <= tag_ch[p][s-1];
                end
            end
        end
    end

    // Steer bank read data to the channel named by the tag. A channel gets
    // at most one grant per cycle, so the two lanes never collide here.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tag_v[0][RD_LAT-1]) begin
            rsp_valid[tag_ch[0][RD_LAT-1]]                 = 1'b1;
            rsp_data[tag_ch[0][RD_LAT-1]*DATA_W +: DATA_W] = Q0;
        end
        if (tag_v[1][RD_LAT-1]) begin
            rsp_valid[tag_ch[1][RD_LAT-1]]                 = 1'b1;
            rsp_data[tag_ch[1][RD_LAT-1]*DATA_W +: DATA_W] = Q1;
        end
    end

endmodule

// File: tb/tb_plm_dp_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_plm_dp_port_arbiter: directed bench for plm_dp_port_arbiter
// (NREQ=4, ADDR_W=12, DATA_W=4, RD_LAT=1) with a behavioural one-cycle
// dual-port bank attached. The bank starts out holding
// mem[a] = a[3:0] ^ a[7:4] ^ a[11:8], so expected read values are easy to
// work out by hand (0x010 -> 1, 0x100 -> 1, 0x7FF -> 7, 0x200 + i -> 2 ^ i).
// ---------------------------------------------------------------------------
module tb_plm_dp_port_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;
    localparam int RD_LAT = 1;

    logic                   CLK;
    logic                   RST;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ*DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0]      A0, A1;
    logic [DATA_W-1:0]      D0, D1;
    logic                   CE0, CE1, WE0, WE1;
    logic [DATA_W-1:0]      WEM0, WEM1;
    logic [DATA_W-1:0]      Q0, Q1;

    int tests_run;
    int fail_count;

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    plm_dp_port_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .A0(A0), .A1(A1), .D0(D0), .D1(D1),
        .CE0(CE0), .CE1(CE1), .WE0(WE0), .WE1(WE1),
        .WEM0(WEM0), .WEM1(WEM1), .Q0(Q0), .Q1(Q1)
    );

    // 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural bank: one-cycle registered read, write on CE & WE.
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = DATA_W'(i[3:0] ^ i[7:4] ^ i[11:8]);
        end
    end

    always @(posedge CLK) begin
        if (CE0) begin
            if (WE0) mem[A0] <= D0;
            else     Q0      <= mem[A0];
        end
        if (CE1) begin
            if (WE1) mem[A1] <= D1;
            else     Q1      <= mem[A1];
        end
    end

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive all channel request inputs at once.
    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] we,
                                 input logic [47:0] addr, input logic [15:0] data);
        req_valid = valid;
        req_we    = we;
        req_addr  = addr;
        req_data  = data;
    endtask

    task automatic go_idle();
        applyStimulus(4'b0000, 4'b0000, 48'h0, 16'h0);
    endtask

    // Inputs change 1 ns after a rising edge; combinational outputs are
    // sampled at the following falling edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        go_idle();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Expected grant pattern and read data for the all-channels test.
    logic [3:0] exp_ready;
    logic [3:0] prev_ready;
    logic [3:0] ch_rd_data [4];
    int         accepts [4];

    initial begin
        tests_run  = 0;
        fail_count = 0;
        Q0 = '0;
        Q1 = '0;
        go_idle();
        RST = 1'b1;
        #2;

        // Outputs while reset is held.
        checkOutput("rst_ce0", 32'(CE0), 32'd0);
        checkOutput("rst_ce1", 32'(CE1), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_wem", 32'({WEM1, WEM0}), 32'd0);
        checkOutput("rst_addr", 32'({A1, A0}), 32'd0);
        do_reset();

        // Idle after reset: nothing moves.
        repeat (3) next_cycle();
        @(negedge CLK);
        checkOutput("idle_ce", 32'({CE1, CE0}), 32'd0);
        checkOutput("idle_ready", 32'(req_ready), 32'd0);
        checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // ch0 read 0x010 + ch2 write 0x020 data 5 in the same cycle.
        next_cycle();
        applyStimulus(4'b0101, 4'b0100, {12'h0, 12'h020, 12'h0, 12'h010},
                      {4'h0, 4'h5, 4'h0, 4'h0});
        @(negedge CLK);
        checkOutput("mix_ready", 32'(req_ready), 32'b0101);
        checkOutput("mix_a0", 32'(A0), 32'h010);
        checkOutput("mix_ce0_we0", 32'({CE0, WE0}), 32'b10);
        checkOutput("mix_wem0", 32'(WEM0), 32'h0);
        checkOutput("mix_a1", 32'(A1), 32'h020);
        checkOutput("mix_d1", 32'(D1), 32'h5);
        checkOutput("mix_ce1_we1", 32'({CE1, WE1}), 32'b11);
        checkOutput("mix_wem1", 32'(WEM1), 32'hF);
        next_cycle();
        go_idle();
        checkOutput("mix_rsp_valid", 32'(rsp_valid), 32'b0001);
        checkOutput("mix_rsp_data0", 32'(rsp_data[3:0]), 32'h1);

        // ch1 write 0x100 vs ch3 read 0x100: only ch1 goes, ch3 follows.
        do_reset();
        applyStimulus(4'b1010, 4'b0010, {12'h100, 12'h0, 12'h100, 12'h0},
                      {4'h0, 4'h0, 4'hA, 4'h0});
        @(negedge CLK);
        checkOutput("conf_ready1", 32'(req_ready), 32'b0010);
        checkOutput("conf_ce1", 32'(CE1), 32'd0);
        checkOutput("conf_port0", 32'({A0, CE0, WE0}), 32'({12'h100, 2'b11}));
        next_cycle();
        applyStimulus(4'b1000, 4'b0000, {12'h100, 12'h0, 12'h0, 12'h0}, 16'h0);
        @(negedge CLK);
        checkOutput("conf_ready2", 32'(req_ready), 32'b1000);
        checkOutput("conf_port0_rd", 32'({A0, CE0, WE0}), 32'({12'h100, 2'b10}));
        checkOutput("conf_no_wr_rsp", 32'(rsp_valid), 32'd0);
        next_cycle();
        go_idle();
        checkOutput("conf_rsp_valid", 32'(rsp_valid), 32'b1000);
        checkOutput("conf_rsp_data3", 32'(rsp_data[15:12]), 32'hA);

        // All four channels read continuously from 0x200+i for 8 cycles.
        do_reset();
        ch_rd_data[0] = 4'h2;
        ch_rd_data[1] = 4'h3;
        ch_rd_data[2] = 4'h0;
        ch_rd_data[3] = 4'h1;
        for (int i = 0; i < 4; i++) accepts[i] = 0;
        prev_ready = 4'b0000;
        applyStimulus(4'b1111, 4'b0000, {12'h203, 12'h202, 12'h201, 12'h200}, 16'h0);
        for (int c = 0; c < 8; c++) begin
            exp_ready = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            @(negedge CLK);
            checkOutput($sformatf("rr_ready_c%0d", c), 32'(req_ready), 32'(exp_ready));
            checkOutput($sformatf("rr_rsp_valid_c%0d", c), 32'(rsp_valid), 32'(prev_ready));
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) accepts[i]++;
                if (prev_ready[i]) begin
                    checkOutput($sformatf("rr_rsp_data_c%0d_ch%0d", c, i),
                                32'(rsp_data[i*4 +: 4]), 32'(ch_rd_data[i]));
                end
            end
            prev_ready = exp_ready;
            next_cycle();
        end
        go_idle();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rr_accepts_ch%0d", i), 32'(accepts[i]), 32'd4);
        end

        // ch0 and ch1 both read 0x7FF in one cycle.
        do_reset();
        applyStimulus(4'b0011, 4'b0000, {12'h0, 12'h0, 12'h7FF, 12'h7FF}, 16'h0);
        @(negedge CLK);
        checkOutput("rr_same_ready", 32'(req_ready), 32'b0011);
        checkOutput("rr_same_ports", 32'({CE1, CE0, A1}), 32'({2'b11, 12'h7FF}));
        next_cycle();
        go_idle();
        checkOutput("rr_same_rsp_valid", 32'(rsp_valid), 32'b0011);
        checkOutput("rr_same_rsp_data", 32'(rsp_data[7:0]), 32'h77);

        // Reset right after two reads are granted: their responses vanish.
        do_reset();
        applyStimulus(4'b1100, 4'b0000, {12'h010, 12'h020, 12'h0, 12'h0}, 16'h0);
        @(negedge CLK);
        checkOutput("rstmid_ready", 32'(req_ready), 32'b1100);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        go_idle();
        #1;
        checkOutput("rstmid_rsp_in_rst", 32'(rsp_valid), 32'd0);
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("rstmid_rsp_release", 32'(rsp_valid), 32'd0);
        next_cycle();
        checkOutput("rstmid_rsp_after", 32'(rsp_valid), 32'd0);
        applyStimulus(4'b1111, 4'b0000, {12'h3, 12'h2, 12'h1, 12'h0}, 16'h0);
        @(negedge CLK);
        checkOutput("rstmid_ptr_zero", 32'(req_ready), 32'b0011);
        next_cycle();
        go_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
